// File: rtl/lc3_console_io.sv
// LC-3 memory-mapped console: keyboard (KBSR/KBDR) and display (DSR/DDR) device registers.
// Optional feature macro: LC3_CONSOLE_KBD_FIFO_EN selects a 4-entry keyboard FIFO instead of
// the default single-character keyboard register.
module lc3_console_io (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic        MEM_WE,
  input  logic        RD_ACK,
  output logic        IO_SEL,
  output logic [15:0] RDATA,
  input  logic        KB_VALID,
  input  logic [7:0]  KB_CHAR,
  output logic        KB_READY,
  output logic        DSP_VALID,
  output logic [7:0]  DSP_CHAR,
  input  logic        DSP_ACK,
  output logic        INT
);

  localparam logic [15:0] AddrKbsr = 16'hFE00;
  localparam logic [15:0] AddrKbdr = 16'hFE02;
  localparam logic [15:0] AddrDsr  = 16'hFE04;
  localparam logic [15:0] AddrDdr  = 16'hFE06;

  typedef enum logic {StIdle, StBusy} dsp_state_e;

  logic       w_hit_kbsr, w_hit_kbdr, w_hit_dsr, w_hit_ddr;
  logic       w_push, w_pop, w_kb_rdy, w_full_d;
  logic [7:0] w_head;
  logic       r_kb_ready, r_ie, r_int;
  logic [7:0] r_dsp_char;
  dsp_state_e r_dsp_state, w_dsp_state_d;
  logic       w_dsp_load;

  assign w_hit_kbsr = (ADDR == AddrKbsr);
  assign w_hit_kbdr = (ADDR == AddrKbdr);
  assign w_hit_dsr  = (ADDR == AddrDsr);
  assign w_hit_ddr  = (ADDR == AddrDdr);
  assign IO_SEL     = w_hit_kbsr | w_hit_kbdr | w_hit_dsr | w_hit_ddr;

  // KB_READY is registered as !full, so an accepted push can never overflow the store.
  assign w_push = KB_VALID & r_kb_ready;
  assign w_pop  = RD_ACK & w_hit_kbdr & w_kb_rdy;

`ifdef LC3_CONSOLE_KBD_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0] r_count, w_count_d;

  assign w_kb_rdy = (r_count != 3'd0);
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_full_d = (w_count_d == 3'd4);

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + 3'd1;
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - 3'd1;
    end
  end

  // FIFO storage; contents are don't-care while the pointers mark it empty.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= KB_CHAR;
    end
  end

  // FIFO pointers and occupancy; 2-bit pointers wrap naturally.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= w_count_d;
    end
  end
`else
  logic [7:0] r_kb_data;
  logic       r_kb_full;

  assign w_kb_rdy = r_kb_full;
  assign w_head   = r_kb_data;
  // A push is only possible while empty, so it always leaves the register full.
  assign w_full_d = w_push | (r_kb_full & ~w_pop);

  // Single-character keyboard holding register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kb_data <= 8'h00;
      r_kb_full <= 1'b0;
    end else begin
      if (w_push) r_kb_data <= KB_CHAR;
      r_kb_full <= w_full_d;
    end
  end
`endif

  // Keyboard ready flag, interrupt enable and registered interrupt request.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kb_ready <= 1'b1;
      r_ie       <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      r_kb_ready <= ~w_full_d;
      if (MEM_WE && w_hit_kbsr) r_ie <= WDATA[14];
      r_int <= w_kb_rdy & r_ie;
    end
  end

  assign KB_READY = r_kb_ready;
  assign INT      = r_int;

  // Display FSM next state: writes to DDR are only accepted while idle.
  always_comb begin
    w_dsp_state_d = r_dsp_state;
    w_dsp_load    = 1'b0;
    unique case (r_dsp_state)
      StIdle: begin
        if (MEM_WE && w_hit_ddr) begin
          w_dsp_load    = 1'b1;
          w_dsp_state_d = StBusy;
        end
      end
      StBusy: begin
        if (DSP_ACK) w_dsp_state_d = StIdle;
      end
      default: w_dsp_state_d = StIdle;
    endcase
  end

  // Display state and character register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dsp_state <= StIdle;
      r_dsp_char  <= 8'h00;
    end else begin
      r_dsp_state <= w_dsp_state_d;
      if (w_dsp_load) r_dsp_char <= WDATA[7:0];
    end
  end

  assign DSP_VALID = (r_dsp_state == StBusy);
  assign DSP_CHAR  = r_dsp_char;

  // Device register read mux; KBDR reads zero while the keyboard store is empty.
  always_comb begin
    RDATA = 16'h0000;
    if (w_hit_kbsr)      RDATA = {w_kb_rdy, r_ie, 14'b0};
    else if (w_hit_kbdr) RDATA = {8'h00, (w_kb_rdy ? w_head : 8'h00)};
    else if (w_hit_dsr)  RDATA = {(r_dsp_state == StIdle), 15'b0};
    else if (w_hit_ddr)  RDATA = {8'h00, r_dsp_char};
  end

endmodule

// File: tb/tb_lc3_console_io.sv
// Self-checking bench for lc3_console_io: directed scenarios followed by random traffic,
// all compared against a queue-based model of the console registers.
module tb_lc3_console_io;

`ifdef LC3_CONSOLE_KBD_FIFO_EN
  localparam int Depth = 4;
`else
  localparam int Depth = 1;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] ADDR, WDATA, RDATA;
  logic        MEM_WE, RD_ACK, IO_SEL;
  logic        KB_VALID, KB_READY, DSP_VALID, DSP_ACK, INT;
  logic [7:0]  KB_CHAR, DSP_CHAR;

  lc3_console_io dut (
    .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .WDATA(WDATA), .MEM_WE(MEM_WE),
    .RD_ACK(RD_ACK), .IO_SEL(IO_SEL), .RDATA(RDATA), .KB_VALID(KB_VALID),
    .KB_CHAR(KB_CHAR), .KB_READY(KB_READY), .DSP_VALID(DSP_VALID), .DSP_CHAR(DSP_CHAR),
    .DSP_ACK(DSP_ACK), .INT(INT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  logic       m_ie, m_int, m_busy;
  logic [7:0] m_dchar;

  task automatic model_reset();
    m_q.delete();
    m_ie = 1'b0; m_int = 1'b0; m_busy = 1'b0; m_dchar = 8'h00;
  endtask

  // One rising edge of the console seen from the specification's rules.
  task automatic model_edge();
    bit push, pop;
    push = KB_VALID && (m_q.size() < Depth);
    pop  = RD_ACK && (ADDR == 16'hFE02) && (m_q.size() > 0);
    m_int = (m_q.size() > 0) && m_ie;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(KB_CHAR);
    if (MEM_WE && ADDR == 16'hFE00) m_ie = WDATA[14];
    if (!m_busy && MEM_WE && ADDR == 16'hFE06) begin
      m_busy = 1'b1; m_dchar = WDATA[7:0];
    end else if (m_busy && DSP_ACK) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic expect16(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] e_rd;
    bit          sel, skip;
    skip = 1'b0;
    sel  = 1'b1;
    case (ADDR)
      16'hFE00: e_rd = {(m_q.size() > 0), m_ie, 14'b0};
      16'hFE02: begin
        skip = (m_q.size() == 0);
        e_rd = skip ? 16'h0000 : {8'h00, m_q[0]};
      end
      16'hFE04: e_rd = {!m_busy, 15'b0};
      16'hFE06: e_rd = {8'h00, m_dchar};
      default: begin e_rd = 16'h0000; sel = 1'b0; end
    endcase
    expect16("io_sel", {15'b0, IO_SEL}, {15'b0, sel});
    if (!skip) expect16("rdata", RDATA, e_rd);
    expect16("kb_ready", {15'b0, KB_READY}, {15'b0, (m_q.size() < Depth)});
    expect16("int", {15'b0, INT}, {15'b0, m_int});
    expect16("dsp_valid", {15'b0, DSP_VALID}, {15'b0, m_busy});
    expect16("dsp_char", {8'h00, DSP_CHAR}, {8'h00, m_dchar});
  endtask

  // Apply inputs just after a falling edge and check the combinational/registered view.
  task automatic drive(input logic [15:0] a, input logic [15:0] wd, input logic we,
                       input logic ack, input logic kv, input logic [7:0] kc, input logic da);
    ADDR = a; WDATA = wd; MEM_WE = we; RD_ACK = ack; KB_VALID = kv; KB_CHAR = kc;
    DSP_ACK = da;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_at(input logic [15:0] a);
    drive(a, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] c;
    logic [15:0] a;
    RESET_N = 1'b0;
    ADDR = 16'h0000; WDATA = 16'h0000; MEM_WE = 0; RD_ACK = 0;
    KB_VALID = 0; KB_CHAR = 8'h00; DSP_ACK = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    idle_at(16'hFE04);
    expect16("rst_dsr", RDATA, 16'h8000);
    RESET_N = 1'b1;
    tick();

    // Keyboard path.
    drive(16'hFE00, 16'h0, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0); tick();
    idle_at(16'hFE00); expect16("kbsr_rdy", RDATA, 16'h8000); tick();
    drive(16'hFE02, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    expect16("kbdr_41", RDATA, 16'h0041); tick();
    idle_at(16'hFE00); expect16("kbsr_empty", RDATA, 16'h0000); tick();

    // Display path.
    drive(16'hFE06, 16'h0158, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    idle_at(16'hFE04);
    expect16("dsp_busy_valid", {15'b0, DSP_VALID}, 16'h0001);
    expect16("dsp_busy_char", {8'h00, DSP_CHAR}, 16'h0058);
    expect16("dsr_busy", RDATA, 16'h0000); tick();
    drive(16'hFE04, 16'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    idle_at(16'hFE04);
    expect16("dsp_done_valid", {15'b0, DSP_VALID}, 16'h0000);
    expect16("dsr_idle", RDATA, 16'h8000); tick();

    // Busy-write drop, including a write in the ack cycle.
    drive(16'hFE06, 16'h0041, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    drive(16'hFE06, 16'h0042, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    idle_at(16'hFE06); expect16("drop_char", {8'h00, DSP_CHAR}, 16'h0041); tick();
    drive(16'hFE06, 16'h0043, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    idle_at(16'hFE06);
    expect16("drop_valid", {15'b0, DSP_VALID}, 16'h0000);
    expect16("drop_ack_char", {8'h00, DSP_CHAR}, 16'h0041); tick();

    // Interrupt enable; writes to KBDR/DSR must be ignored.
    drive(16'hFE00, 16'h4000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    drive(16'hFE02, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0); tick();
    drive(16'hFE04, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    idle_at(16'hFE00); expect16("int_set", {15'b0, INT}, 16'h0001); tick();
    drive(16'hFE02, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    idle_at(16'hFE00); tick();
    idle_at(16'hFE00); expect16("int_clr", {15'b0, INT}, 16'h0000); tick();

    // Fill the keyboard store with KB_VALID held, then pop in order.
    c = 8'h31;
    for (int i = 0; i < Depth + 2; i++) begin
      drive(16'hFE00, 16'h0, 1'b0, 1'b0, 1'b1, c, 1'b0);
      if (m_q.size() < Depth) c++;
      tick();
    end
    drive(16'hFE00, 16'h0, 1'b0, 1'b0, 1'b1, c, 1'b0);
    expect16("full_ready", {15'b0, KB_READY}, 16'h0000);
    tick();
    for (int i = 0; i < Depth + 4; i++) begin
      drive(16'hFE02, 16'h0, 1'b0, 1'b1, (c <= 8'h35), c, 1'b0);
      if (i == 0) expect16("fifo_head", RDATA, 16'h0031);
      if (c <= 8'h35 && m_q.size() < Depth) c++;
      tick();
    end
    for (int i = 0; i < Depth + 1; i++) begin
      drive(16'hFE02, 16'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0); tick();
    end

    // Reset in the middle of a display transfer with keyboard data pending.
    drive(16'hFE06, 16'h0077, 1'b1, 1'b0, 1'b1, 8'h61, 1'b0); tick();
    drive(16'hFE00, 16'h0, 1'b0, 1'b0, 1'b1, 8'h62, 1'b0); tick();
    idle_at(16'hFE00);
    #1 RESET_N = 1'b0;
    model_reset();
    #1;
    check_all();
    expect16("rst_valid", {15'b0, DSP_VALID}, 16'h0000);
    expect16("rst_kbsr", RDATA, 16'h0000);
    expect16("rst_ready", {15'b0, KB_READY}, 16'h0001);
    #1 RESET_N = 1'b1;
    tick();
    idle_at(16'hFE00); tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0: a = 16'hFE00;
        1: a = 16'hFE02;
        2: a = 16'hFE02;
        3: a = 16'hFE04;
        4: a = 16'hFE06;
        5: a = 16'hFE00 + 16'($urandom_range(1, 15));
        default: a = 16'($urandom);
      endcase
      drive(a, 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
